// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
// The lock FSM states are used only when FIFO_ARB_LOCK_EN is defined.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Wrapping increment of a round-robin index over nb requesters.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nb);
      return (ptr + 1 >= nb) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: first asserted request at or above rr_ptr,
// wrapping modulo NB_REQ.
module rr_priority_select #(
   parameter int unsigned NB_REQ   = 4,
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic [NB_REQ-1:0]   req,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic [NB_REQ-1:0]   win_onehot,
   output logic [ID_WIDTH-1:0] win_idx,
   output logic                any_valid
);

   int unsigned       idx;
   logic [NB_REQ-1:0] rot;

   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
      any_valid  = 1'b0;
      idx        = 0;
      rot        = '0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NB_REQ) begin
            idx = idx - NB_REQ;
         end
         // Shift instead of a variable bit-select to keep index widths exact.
         rot = req >> idx;
         if (!any_valid && rot[0]) begin
            any_valid  = 1'b1;
            win_idx    = idx[ID_WIDTH-1:0];
            win_onehot = NB_REQ'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one scfifo write port between NB_REQ valid/ready requesters.
// Optional FIFO_ARB_LOCK_EN adds req_last and keeps the grant on one requester per packet.
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NB_REQ     = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic                           swrst,
   input  logic [NB_REQ-1:0]              req_valid,
   input  logic [NB_REQ*DATA_WIDTH-1:0]   req_data,
`ifdef FIFO_ARB_LOCK_EN
   input  logic [NB_REQ-1:0]              req_last,
`endif
   output logic [NB_REQ-1:0]              req_ready,
   output logic                           fifo_push,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data,
   input  logic                           fifo_full,
   output logic [ID_WIDTH-1:0]            grant_id
);

   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [NB_REQ-1:0]     req_masked;
   logic [NB_REQ-1:0]     win_onehot;
   logic [ID_WIDTH-1:0]   win_idx;
   logic                  any_valid;
   logic [DATA_WIDTH-1:0] win_data;
   logic [ID_WIDTH-1:0]   ptr_after_win;

   rr_priority_select #(
      .NB_REQ   (NB_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_select (
      .req        (req_masked),
      .rr_ptr     (rr_ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .any_valid  (any_valid)
   );

   // Reset gates the push combinationally so an in-flight cycle is dropped at once.
   assign fifo_push     = any_valid & ~fifo_full & ~areset & ~swrst;
   assign req_ready     = win_onehot & {NB_REQ{fifo_push}};
   assign win_data      = DATA_WIDTH'(req_data >> (32'(win_idx) * DATA_WIDTH));
   assign fifo_data     = {win_idx, win_data};
   assign grant_id      = win_idx;
   assign ptr_after_win = ID_WIDTH'(rr_next(32'(win_idx), NB_REQ));

`ifdef FIFO_ARB_LOCK_EN
   arb_state_t          state;
   logic [ID_WIDTH-1:0] lock_idx;
   logic                win_last;

   assign win_last   = |(req_last & win_onehot);
   assign req_masked = (state == LOCKED) ? (req_valid & (NB_REQ'(1) << lock_idx)) : req_valid;

   // In LOCKED the winner is always lock_idx, so ptr_after_win is lock_idx+1.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= IDLE;
         lock_idx <= '0;
         rr_ptr   <= '0;
      end else if (swrst) begin
         state    <= IDLE;
         lock_idx <= '0;
         rr_ptr   <= '0;
      end else if (fifo_push) begin
         if (win_last) begin
            state  <= IDLE;
            rr_ptr <= ptr_after_win;
         end else begin
            state    <= LOCKED;
            lock_idx <= win_idx;
         end
      end
   end
`else
   assign req_masked = req_valid;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rr_ptr <= '0;
      end else if (swrst) begin
         rr_ptr <= '0;
      end else if (fifo_push) begin
         rr_ptr <= ptr_after_win;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: queue-based requester/FIFO model drives
// expectations; a negedge monitor pops and compares on every fifo_push.
module tb_fifo_push_arbiter;

   localparam int NB    = 4;
   localparam int DW    = 8;
   localparam int IW    = 2;
   localparam int DEPTH = 8;
`ifdef FIFO_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic              aclk = 1'b0;
   logic              areset, swrst, fifo_full, fifo_push;
   logic [NB-1:0]     req_valid, req_ready, req_last;
   logic [NB*DW-1:0]  req_data;
   logic [IW+DW-1:0]  fifo_data;
   logic [IW-1:0]     grant_id;

   typedef struct packed {
      logic [NB-1:0] ready;
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [DW:0] pend[NB][$];   // {last, data} words waiting at each requester
   int n_tests = 0, n_fail = 0, n_pushes = 0, n_exp = 0;
   int ptr = 0, lock_idx = 0, occ = 0, pop_pct = 100;
   bit locked = 1'b0, force_full = 1'b0;

   fifo_push_arbiter #(
      .NB_REQ     (NB),
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .swrst     (swrst),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef FIFO_ARB_LOCK_EN
      .req_last  (req_last),
`endif
      .req_ready (req_ready),
      .fifo_push (fifo_push),
      .fifo_data (fifo_data),
      .fifo_full (fifo_full),
      .grant_id  (grant_id)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_word(input int r, input logic [DW-1:0] d, input bit last);
      pend[r].push_back({last, d});
   endtask

   task automatic add_packet(input int r, input int len);
      for (int j = 0; j < len; j++) add_word(r, DW'($urandom), j == len - 1);
   endtask

   task automatic model_reset();
      ptr    = 0;
      locked = 1'b0;
   endtask

   // One clock cycle: present head-of-queue words, then let the model decide the transfer.
   task automatic step(input bit srst, input bit arst);
      int win, i;
      logic [DW:0] w;
      exp_t e;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      swrst  = 1'b0;
      for (int r = 0; r < NB; r++) begin
         w = (pend[r].size() > 0) ? pend[r][0] : '0;
         req_valid[r]         = pend[r].size() > 0;
         req_data[r*DW +: DW] = w[DW-1:0];
         req_last[r]          = w[DW];
      end
      fifo_full = force_full || (occ >= DEPTH);
      if (arst) begin
         #1 areset = 1'b1;
         #1;
         check("async_rst_ready", 32'(req_ready), 0);
         check("async_rst_push", 32'(fifo_push), 0);
         model_reset();
      end else if (srst) begin
         swrst = 1'b1;
         #1;
         check("sync_rst_push", 32'(fifo_push), 0);
         model_reset();
      end else begin
         win = -1;
         for (int k = 0; k < NB; k++) begin
            i = (ptr + k) % NB;
            if (win < 0 && pend[i].size() > 0 && (!locked || i == lock_idx)) win = i;
         end
         if (win >= 0 && !fifo_full) begin
            w = pend[win].pop_front();
            e.ready = NB'(1) << win;
            e.id    = IW'(win);
            e.data  = w[DW-1:0];
            exp_q.push_back(e);
            n_exp++;
            occ++;
            if (w[DW] || !LOCK_EN) begin
               ptr    = (win + 1) % NB;
               locked = 1'b0;
            end else begin
               locked   = 1'b1;
               lock_idx = win;
            end
         end
      end
      if (occ > 0 && $urandom_range(99, 0) < pop_pct) occ--;
   endtask

   function automatic int pending_total();
      int s = 0;
      for (int r = 0; r < NB; r++) s += pend[r].size();
      return s;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge aclk);
         if (fifo_push === 1'b1) begin
            n_pushes++;
            check("no_push_when_full", 32'(fifo_full), 0);
            if (exp_q.size() == 0) begin
               check("unexpected_push", 32'(fifo_data), 32'h0dead);
            end else begin
               e = exp_q.pop_front();
               check("fifo_data", 32'(fifo_data), 32'({e.id, e.data}));
               check("grant_id", 32'(grant_id), 32'(e.id));
               check("req_ready", 32'(req_ready), 32'(e.ready));
            end
         end
      end
   end

   initial begin : stimulus
      int guard;
      areset = 1'b1; swrst = 1'b0; fifo_full = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;
      repeat (2) @(posedge aclk);
      #1 req_valid = '1;
      #1;
      check("reset_ready", 32'(req_ready), 0);
      check("reset_push", 32'(fifo_push), 0);

      // Fairness: two rounds with every requester valid.
      for (int r = 0; r < NB; r++) begin
         add_word(r, DW'(8'h10 + r), 1'b1);
         add_word(r, DW'(8'h20 + r), 1'b1);
      end
      repeat (8) step(1'b0, 1'b0);

      // Lone requester 2.
      add_word(2, 8'hA5, 1'b1);
      repeat (3) step(1'b0, 1'b0);

      // FIFO full for three cycles with all valid.
      for (int r = 0; r < NB; r++) repeat (2) add_packet(r, 1);
      force_full = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      force_full = 1'b0;
      repeat (10) step(1'b0, 1'b0);

      // Async reset mid-stream with the pointer at 2, then sync reset.
      add_word(1, 8'h5A, 1'b1);
      step(1'b0, 1'b0);
      for (int r = 0; r < NB; r++) repeat (3) add_packet(r, 1);
      step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);

`ifdef FIFO_ARB_LOCK_EN
      // Packet lock: three-word packet from requester 1 against competitors 0 and 3.
      add_word(0, 8'h01, 1'b1);
      step(1'b0, 1'b0);
      add_word(1, 8'hB1, 1'b0);
      add_word(1, 8'hB2, 1'b0);
      add_word(1, 8'hB3, 1'b1);
      add_word(0, 8'hC0, 1'b1);
      add_word(3, 8'hD3, 1'b1);
      repeat (8) step(1'b0, 1'b0);
`endif

      // Random traffic into a depth-8 FIFO drained at a random rate.
      pop_pct = 40;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < NB; r++)
            if ($urandom_range(3, 0) == 0 && pend[r].size() < 4) add_packet(r, $urandom_range(3, 1));
         step($urandom_range(99, 0) == 0, 1'b0);
      end

      pop_pct = 100;
      guard = 0;
      while (pending_total() > 0 && guard < 1000) begin
         step(1'b0, 1'b0);
         guard++;
      end
      repeat (4) step(1'b0, 1'b0);
      @(negedge aclk);
      #1;
      check("drain_done", 32'(pending_total()), 0);
      check("queue_empty", 32'(exp_q.size()), 0);
      check("push_count", 32'(n_pushes), 32'(n_exp));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
